debug_loader_ctrl: RTL and testbench

- Sequences the MIPS pipeline from the UART side. Drains bytes from the RX FIFO and assembles little-endian 32-bit instructions, which it writes into instruction memory.
- A 0xFFFFFFFF sentinel ends program load. A mode byte then selects continuous or single-step execution.
- Gates the pipeline enable. On halt, reports the final PC as 4 bytes through the UART TX.
- Sits between the UART RX FIFO/TX and the pipeline top.

---
 rtl/debug_loader_ctrl_if.sv | 35 +++
 rtl/debug_loader_ctrl.sv | 177 +++++++++++++++++
 tb/tb_debug_loader_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/debug_loader_ctrl_if.sv
// UART-side and pipeline-side signal bundle for the debug loader.
// master = the loader controller, slave = the FIFO/TX/pipeline environment.
interface debug_loader_ctrl_if #(
  parameter int NB_DATA  = 32,
  parameter int NB_BYTE  = 8,
  parameter int NB_ADDR  = 7,
  parameter int NB_STATE = 10
);
  logic [NB_BYTE-1:0]  rx_data;
  logic                rx_empty;
  logic                rx_read;
  logic                instr_wr_en;
  logic [NB_ADDR-1:0]  instr_wr_addr;
  logic [NB_DATA-1:0]  instr_wr_data;
  logic                pipeline_enable;
  logic                halt_i;
  logic [NB_DATA-1:0]  pc_i;
  logic [NB_BYTE-1:0]  tx_data;
  logic                tx_start;
  logic                tx_done;
  logic                finish_o;
  logic [NB_STATE-1:0] state_o;

  modport master (
    input  rx_data, rx_empty, halt_i, pc_i, tx_done,
    output rx_read, instr_wr_en, instr_wr_addr, instr_wr_data,
           pipeline_enable, tx_data, tx_start, finish_o, state_o
  );

  modport slave (
    output rx_data, rx_empty, halt_i, pc_i, tx_done,
    input  rx_read, instr_wr_en, instr_wr_addr, instr_wr_data,
           pipeline_enable, tx_data, tx_start, finish_o, state_o
  );
endinterface

// File: rtl/debug_loader_ctrl.sv
// Debug loader: assembles little-endian instruction words from the UART RX
// FIFO into instruction memory, selects run/step mode, gates the pipeline and
// reports the final PC back through the UART TX, LSB first.
module debug_loader_ctrl #(
  parameter int NB_DATA  = 32,
  parameter int NB_BYTE  = 8,
  parameter int NB_ADDR  = 7,
  parameter int NB_STATE = 10
) (
  input  logic               clock,
  input  logic               reset,
  debug_loader_ctrl_if.master bus
);
  localparam int BPW = NB_DATA / NB_BYTE;     // bytes per word
  localparam int CW  = $clog2(BPW + 1);       // counter holds 0..BPW

  localparam logic [NB_DATA-1:0] SENTINEL = '1;
  localparam logic [NB_BYTE-1:0] CMD_RUN  = NB_BYTE'(1);
  localparam logic [NB_BYTE-1:0] CMD_STEP = NB_BYTE'(2);
  localparam logic [NB_BYTE-1:0] CMD_STOP = NB_BYTE'(3);

  typedef enum logic [NB_STATE-1:0] {
    LOAD_WAIT  = NB_STATE'(1),
    LOAD_POP   = NB_STATE'(2),
    LOAD_WRITE = NB_STATE'(4),
    MODE_WAIT  = NB_STATE'(8),
    RUN        = NB_STATE'(16),
    STEP_WAIT  = NB_STATE'(32),
    STEP_PULSE = NB_STATE'(64),
    SEND_BYTE  = NB_STATE'(128),
    SEND_WAIT  = NB_STATE'(256),
    DONE       = NB_STATE'(512)
  } state_t;

  state_t             state;
  logic [NB_BYTE-1:0] rx_byte;
  logic [NB_DATA-1:0] shreg;
  logic [CW-1:0]      byte_cnt;
  logic [CW-1:0]      tx_cnt;
  logic [NB_ADDR-1:0] waddr;
  logic [NB_DATA-1:0] pc_q;

  logic               rx_read_q;
  logic               wr_en_q;
  logic [NB_ADDR-1:0] wr_addr_q;
  logic [NB_DATA-1:0] wr_data_q;
  logic               pen_q;
  logic [NB_BYTE-1:0] tx_data_q;
  logic               tx_start_q;
  logic               finish_q;

  assign bus.rx_read         = rx_read_q;
  assign bus.instr_wr_en     = wr_en_q;
  assign bus.instr_wr_addr   = wr_addr_q;
  assign bus.instr_wr_data   = wr_data_q;
  assign bus.pipeline_enable = pen_q;
  assign bus.tx_data         = tx_data_q;
  assign bus.tx_start        = tx_start_q;
  assign bus.finish_o        = finish_q;
  assign bus.state_o         = state;

  // Single control FSM; every output is a register set on the edge that
  // leaves (or stays in) the state that requests it. Mode/step byte intake
  // is skipped while rx_read is still high so the FIFO head, which has not
  // advanced yet, is never consumed twice.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= LOAD_WAIT;
      rx_byte    <= '0;
      shreg      <= '0;
      byte_cnt   <= '0;
      tx_cnt     <= '0;
      waddr      <= '0;
      pc_q       <= '0;
      rx_read_q  <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      pen_q      <= 1'b0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      finish_q   <= 1'b0;
    end else begin
      rx_read_q  <= 1'b0;
      wr_en_q    <= 1'b0;
      tx_start_q <= 1'b0;
      pen_q      <= 1'b0;
      case (state)
        LOAD_WAIT: begin
          if (!bus.rx_empty) begin
            rx_byte   <= bus.rx_data;
            rx_read_q <= 1'b1;
            state     <= LOAD_POP;
          end
        end
        LOAD_POP: begin
          // bytes enter at the top and move down, so byte n ends at bits [8n+7:8n]
          shreg    <= {rx_byte, shreg[NB_DATA-1:NB_BYTE]};
          byte_cnt <= byte_cnt + CW'(1);
          state    <= (byte_cnt == CW'(BPW - 1)) ? LOAD_WRITE : LOAD_WAIT;
        end
        LOAD_WRITE: begin
          byte_cnt <= '0;
          if (shreg == SENTINEL) begin
            state <= MODE_WAIT;
          end else begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= waddr;
            wr_data_q <= shreg;
            waddr     <= waddr + NB_ADDR'(1);
            // a full memory ends the load instead of wrapping onto word 0
            state     <= (waddr == '1) ? MODE_WAIT : LOAD_WAIT;
          end
        end
        MODE_WAIT: begin
          if (!bus.rx_empty && !rx_read_q) begin
            rx_read_q <= 1'b1;
            if (bus.rx_data == CMD_RUN) begin
              pen_q <= 1'b1;
              state <= RUN;
            end else if (bus.rx_data == CMD_STEP) begin
              state <= STEP_WAIT;
            end
          end
        end
        RUN: begin
          if (bus.halt_i) begin
            pc_q  <= bus.pc_i;
            state <= SEND_BYTE;
          end else begin
            pen_q <= 1'b1;
          end
        end
        STEP_WAIT: begin
          if (!bus.rx_empty && !rx_read_q) begin
            rx_read_q <= 1'b1;
            if (bus.rx_data == CMD_STEP) begin
              pen_q <= 1'b1;
              state <= STEP_PULSE;
            end else if (bus.rx_data == CMD_STOP) begin
              pc_q  <= bus.pc_i;
              state <= SEND_BYTE;
            end
          end
        end
        STEP_PULSE: begin
          if (bus.halt_i) begin
            pc_q  <= bus.pc_i;
            state <= SEND_BYTE;
          end else begin
            state <= STEP_WAIT;
          end
        end
        SEND_BYTE: begin
          tx_data_q  <= NB_BYTE'(pc_q >> (int'(tx_cnt) * NB_BYTE));
          tx_start_q <= 1'b1;
          state      <= SEND_WAIT;
        end
        SEND_WAIT: begin
          if (bus.tx_done) begin
            tx_cnt <= tx_cnt + CW'(1);
            if (tx_cnt == CW'(BPW - 1)) begin
              finish_q <= 1'b1;
              state    <= DONE;
            end else begin
              state <= SEND_BYTE;
            end
          end
        end
        DONE: begin
          finish_q <= 1'b1;
        end
        default: state <= LOAD_WAIT;
      endcase
    end
  end
endmodule

// File: tb/tb_debug_loader_ctrl.sv
// Bench for debug_loader_ctrl: FWFT RX FIFO model, TX responder with random
// latency, scoreboard of memory writes / pops / enable cycles / TX bytes.
module tb_debug_loader_ctrl;
  localparam int NB_DATA = 32, NB_BYTE = 8, NB_ADDR = 7, NB_STATE = 10;
  localparam logic [61:0] RST_OUTS = {1'b0, 1'b0, 7'd0, 32'd0, 1'b0, 8'd0, 1'b0, 1'b0, 10'h001};

  logic clock = 1'b0;
  logic reset = 1'b1;

  debug_loader_ctrl_if #(.NB_DATA(NB_DATA), .NB_BYTE(NB_BYTE), .NB_ADDR(NB_ADDR), .NB_STATE(NB_STATE)) bus();
  debug_loader_ctrl #(.NB_DATA(NB_DATA), .NB_BYTE(NB_BYTE), .NB_ADDR(NB_ADDR), .NB_STATE(NB_STATE))
    dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  typedef struct { int addr; logic [31:0] data; int neg; } wr_t;

  int checks = 0, errors = 0;
  byte unsigned fifo[$];
  byte unsigned feed[$];
  byte unsigned stream[$];
  logic [31:0]  exp_q[$];
  wr_t          wr_log[$];
  byte unsigned tx_log[$];
  int           tx_start_neg[$];
  int neg_cnt = 0, rd_cnt = 0, en_cnt = 0, en_pulses = 0, last_push_neg = 0, tx_dly = 0;
  logic en_prev = 1'b0, tx_busy = 1'b0;
  bit   spurious = 0;
  int   feed_pct = 75;

  function automatic logic [61:0] outs();
    return {bus.rx_read, bus.instr_wr_en, bus.instr_wr_addr, bus.instr_wr_data,
            bus.pipeline_enable, bus.tx_data, bus.tx_start, bus.finish_o, bus.state_o};
  endfunction

  // Environment: monitor, FIFO (pop on rx_read, random refill), TX responder.
  always @(negedge clock) begin
    neg_cnt <= neg_cnt + 1;
    if (reset) begin
      wr_log.delete(); tx_log.delete(); tx_start_neg.delete(); fifo.delete();
      rd_cnt <= 0; en_cnt <= 0; en_pulses <= 0; en_prev <= 1'b0; tx_busy <= 1'b0;
      bus.tx_done <= 1'b0; bus.rx_empty <= 1'b1; bus.rx_data <= 8'h00;
    end else begin
      if (bus.instr_wr_en) wr_log.push_back('{int'(bus.instr_wr_addr), bus.instr_wr_data, neg_cnt});
      if (bus.rx_read) rd_cnt <= rd_cnt + 1;
      if (bus.pipeline_enable) en_cnt <= en_cnt + 1;
      if (bus.pipeline_enable && !en_prev) en_pulses <= en_pulses + 1;
      en_prev <= bus.pipeline_enable;
      if (bus.rx_read && fifo.size() != 0) void'(fifo.pop_front());
      if (feed.size() != 0 && $urandom_range(0, 99) < feed_pct) begin
        fifo.push_back(feed.pop_front());
        last_push_neg <= neg_cnt;
      end
      bus.rx_empty <= (fifo.size() == 0);
      bus.rx_data  <= (fifo.size() != 0) ? fifo[0] : 8'h00;
      bus.tx_done <= 1'b0;
      if (tx_busy) begin
        if (tx_dly <= 1) begin bus.tx_done <= 1'b1; tx_busy <= 1'b0; end
        else tx_dly <= tx_dly - 1;
      end
      if (bus.tx_start) begin
        tx_log.push_back(bus.tx_data);
        tx_start_neg.push_back(neg_cnt);
        tx_dly  <= $urandom_range(1, 4);
        tx_busy <= 1'b1;
      end
      if (spurious && bus.state_o == 10'h080) bus.tx_done <= 1'b1;
    end
  end

  // Reference: split the byte stream into little-endian words, stop at the
  // sentinel or when the 128-word memory is full.
  function automatic void model_load();
    logic [31:0] w;
    exp_q.delete();
    for (int i = 0; i + 3 < stream.size(); i += 4) begin
      w = {stream[i+3], stream[i+2], stream[i+1], stream[i]};
      if (w == 32'hFFFF_FFFF || exp_q.size() == 128) break;
      exp_q.push_back(w);
    end
  endfunction

  function automatic byte unsigned junk();
    byte unsigned b;
    do b = 8'($urandom_range(0, 255)); while (b == 8'h01 || b == 8'h02 || b == 8'h03);
    return b;
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    do w = $urandom(); while (w == 32'hFFFF_FFFF);
    return w;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic feed_byte(input byte unsigned b);
    feed.push_back(b);
    stream.push_back(b);
  endtask

  task automatic feed_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) feed_byte(w[8*i +: 8]);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; bus.halt_i = 1'b0; bus.pc_i = '0; spurious = 0; feed_pct = 75;
    tick(1);
    feed.delete(); stream.delete();
    tick(2);
    reset = 1'b0;
    tick(2);
  endtask

  task automatic wait_drain(input int budget, input string nm);
    int n = 0;
    while ((feed.size() != 0 || fifo.size() != 0 || bus.rx_read) && n < budget) begin tick(1); n++; end
    checks++;
    if (n >= budget) begin errors++; $display("FAIL %s rx drain timeout after %0d cycles", nm, n); end
    tick(8);
  endtask

  task automatic wait_finish(input int budget, input string nm);
    int n = 0;
    while (!bus.finish_o && n < budget) begin tick(1); n++; end
    checks++;
    if (n >= budget) begin errors++; $display("FAIL %s finish_o timeout after %0d cycles", nm, n); end
    tick(2);
  endtask

  task automatic check_tx(input logic [31:0] pcv, input string nm);
    checks++;
    if (tx_log.size() !== 4) begin
      errors++; $display("FAIL %s tx count got %0d exp 4", nm, tx_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (tx_log[i] !== pcv[8*i +: 8]) begin
          errors++; $display("FAIL %s tx byte %0d got %h exp %h", nm, i, tx_log[i], pcv[8*i +: 8]);
        end
      end
    end
  endtask

  task automatic check_writes(input string nm);
    model_load();
    checks++;
    if (wr_log.size() !== exp_q.size()) begin
      errors++; $display("FAIL %s write count got %0d exp %0d", nm, wr_log.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (wr_log[i].addr !== i || wr_log[i].data !== exp_q[i]) begin
          errors++;
          $display("FAIL %s write %0d got addr %0d data %h exp addr %0d data %h",
                   nm, i, wr_log[i].addr, wr_log[i].data, i, exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clock); reset = 1'b1; tick(2);
    checks++;
    if (outs() !== RST_OUTS) begin errors++; $display("FAIL reset_held got %h exp %h", outs(), RST_OUTS); end
    reset = 1'b0; tick(4);
    checks++;
    if (outs() !== RST_OUTS) begin errors++; $display("FAIL reset_idle got %h exp %h", outs(), RST_OUTS); end
  endtask

  task automatic test_load_basic();
    byte unsigned b[8] = '{8'h00, 8'h00, 8'h23, 8'h80, 8'h21, 8'h18, 8'hE2, 8'h00};
    do_reset();
    foreach (b[i]) feed_byte(b[i]);
    wait_drain(300, "load_basic");
    check_writes("load_basic");
    checks++;
    if (wr_log.size() != 2 || wr_log[1].data !== 32'h00E2_1821) begin
      errors++; $display("FAIL load_basic second word got %0d writes", wr_log.size());
    end
    checks++;
    if (rd_cnt !== 8) begin errors++; $display("FAIL load_basic rx_read pulses got %0d exp 8", rd_cnt); end
    checks++;
    if (bus.state_o !== 10'h001) begin errors++; $display("FAIL load_basic state got %h exp 001", bus.state_o); end
  endtask

  task automatic test_latency();
    do_reset(); feed_pct = 100;
    feed_byte(8'h12); feed_byte(8'h34); feed_byte(8'h56);
    wait_drain(100, "latency");
    feed_byte(8'h78);
    wait_drain(100, "latency");
    checks++;
    if (wr_log.size() != 1 || wr_log[0].neg - last_push_neg !== 3 || wr_log[0].data !== 32'h7856_3412) begin
      errors++; $display("FAIL latency writes %0d delay got %0d exp 3", wr_log.size(),
                         (wr_log.size() != 0) ? wr_log[0].neg - last_push_neg : -1);
    end
  endtask

  task automatic test_load_random();
    int r;
    byte unsigned j;
    for (int it = 0; it < 3; it++) begin
      do_reset();
      for (int k = 0; k < $urandom_range(3, 20); k++) feed_word(rand_word());
      feed_word(32'hFFFF_FFFF);
      wait_drain(2000, "load_random");
      check_writes("load_random");
      checks++;
      if (bus.state_o !== 10'h008) begin errors++; $display("FAIL sentinel state got %h exp 008", bus.state_o); end
      r = rd_cnt; j = junk();
      feed_byte(j);
      wait_drain(100, "bad_mode");
      checks++;
      if (rd_cnt !== r + 1 || bus.state_o !== 10'h008) begin
        errors++; $display("FAIL bad_mode %h pops got %0d exp %0d state %h", j, rd_cnt - r, 1, bus.state_o);
      end
    end
  endtask

  task automatic test_run();
    int low = 0, hn, r;
    logic [31:0] pcv = 32'h0000_000C;
    do_reset(); spurious = 1;
    feed_word(rand_word()); feed_word(32'hFFFF_FFFF); feed_byte(8'h01);
    wait_drain(300, "run");
    checks++;
    if (bus.state_o !== 10'h010) begin errors++; $display("FAIL run state got %h exp 010", bus.state_o); end
    repeat (20) begin tick(1); if (bus.pipeline_enable !== 1'b1) low++; end
    checks++;
    if (low !== 0) begin errors++; $display("FAIL run enable low cycles got %0d exp 0", low); end
    bus.pc_i = pcv; bus.halt_i = 1'b1; hn = neg_cnt;
    wait_finish(200, "run");
    check_tx(pcv, "run");
    checks++;
    if (tx_start_neg.size() == 0 || tx_start_neg[0] - hn !== 2) begin
      errors++; $display("FAIL halt_to_tx latency got %0d exp 2",
                         (tx_start_neg.size() != 0) ? tx_start_neg[0] - hn : -1);
    end
    checks++;
    if (bus.finish_o !== 1'b1 || bus.state_o !== 10'h200 || bus.pipeline_enable !== 1'b0) begin
      errors++; $display("FAIL run_done finish %b state %h en %b exp 1 200 0",
                         bus.finish_o, bus.state_o, bus.pipeline_enable);
    end
    r = rd_cnt;
    feed_byte(8'h01); feed_byte(8'h02);
    tick(20);
    checks++;
    if (rd_cnt !== r || bus.state_o !== 10'h200) begin
      errors++; $display("FAIL done_no_pop pops got %0d exp 0 state %h", rd_cnt - r, bus.state_o);
    end
  endtask

  task automatic test_halt_early();
    logic [31:0] pcv = $urandom();
    do_reset();
    feed_word(32'hFFFF_FFFF);
    bus.pc_i = pcv; bus.halt_i = 1'b1;
    feed_byte(8'h01);
    wait_finish(300, "halt_early");
    checks++;
    if (en_cnt !== 1) begin errors++; $display("FAIL halt_early enable cycles got %0d exp 1", en_cnt); end
    check_tx(pcv, "halt_early");
  endtask

  task automatic test_step(input int k, input logic [31:0] pcv, input bit use_junk);
    do_reset();
    feed_word(rand_word()); feed_word(32'hFFFF_FFFF); feed_byte(8'h02);
    for (int i = 0; i < k; i++) begin
      if (use_junk && $urandom_range(0, 1) == 1) feed_byte(junk());
      feed_byte(8'h02);
    end
    wait_drain(400, "step");
    checks++;
    if (en_pulses !== k || en_cnt !== k) begin
      errors++; $display("FAIL step pulses got %0d cycles %0d exp %0d", en_pulses, en_cnt, k);
    end
    checks++;
    if (bus.state_o !== 10'h020) begin errors++; $display("FAIL step state got %h exp 020", bus.state_o); end
    bus.pc_i = pcv;
    feed_byte(8'h03);
    wait_finish(300, "step");
    check_tx(pcv, "step");
    checks++;
    if (bus.state_o !== 10'h200 || en_cnt !== k) begin
      errors++; $display("FAIL step_done state %h enable cycles %0d exp 200 %0d", bus.state_o, en_cnt, k);
    end
  endtask

  task automatic test_overflow();
    do_reset(); feed_pct = 100;
    for (int i = 0; i < 128; i++) feed_word(rand_word());
    wait_drain(5000, "overflow");
    check_writes("overflow");
    checks++;
    if (wr_log.size() == 0 || wr_log[wr_log.size()-1].addr !== 127 || bus.state_o !== 10'h008) begin
      errors++; $display("FAIL overflow last addr state %h exp 7f 008", bus.state_o);
    end
    feed_word(32'h5555_5555);
    wait_drain(200, "overflow");
    checks++;
    if (wr_log.size() !== 128 || bus.state_o !== 10'h008) begin
      errors++; $display("FAIL overflow_extra writes got %0d exp 128 state %h", wr_log.size(), bus.state_o);
    end
  endtask

  task automatic test_reset_midload();
    int n = 0;
    logic [31:0] w = rand_word();
    do_reset(); feed_pct = 100;
    feed_byte(8'hAA); feed_byte(8'hBB);
    while (rd_cnt < 2 && n < 100) begin tick(1); n++; end
    tick(2);
    reset = 1'b1; tick(1);
    checks++;
    if (outs() !== RST_OUTS) begin errors++; $display("FAIL midload_reset got %h exp %h", outs(), RST_OUTS); end
    tick(1); reset = 1'b0; tick(2);
    feed_word(w);
    wait_drain(200, "midload");
    checks++;
    if (wr_log.size() != 1 || wr_log[0].addr !== 0 || wr_log[0].data !== w) begin
      errors++; $display("FAIL midload writes %0d first %h exp 1 at 0 with %h", wr_log.size(),
                         (wr_log.size() != 0) ? wr_log[0].data : 32'h0, w);
    end
  endtask

  initial begin
    bus.halt_i = 1'b0; bus.pc_i = '0;
    test_reset();
    test_load_basic();
    test_latency();
    test_load_random();
    test_run();
    test_halt_early();
    test_step(3, 32'h0000_0008, 0);
    test_step($urandom_range(1, 6), $urandom(), 1);
    test_overflow();
    test_reset_midload();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
